// File: rtl/echo_effect.sv
// Echo/delay effect between the music player and the codec: one frame in, one mixed frame out.
// Latency: output registered two edges after the edge that samples new_frame (3-cycle latency); no backpressure.
module echo_effect #(
    parameter int DELAY_SAMPLES = 1024,
    parameter int ATTEN_SHIFT   = 1,
    parameter int FEEDBACK      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        new_frame,
    input  logic [15:0] sample_in,
    output logic [15:0] sample_out,
    output logic        out_valid
);
    localparam int AW = $clog2(DELAY_SAMPLES);
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {IDLE, READ, MIX} state_t;

    state_t             state;
    logic [AW-1:0]      ptr;
    logic [FW-1:0]      fill;
    logic signed [15:0] din;
    logic signed [15:0] old;
    logic signed [15:0] rd_dat;
    logic [15:0]        mem [DELAY_SAMPLES];

    logic               fill_full;
    logic signed [15:0] old_att;
    logic signed [16:0] wet_sum;
    logic signed [15:0] wet_sat;
    logic               mem_we;
    logic               mem_re;
    logic [15:0]        mem_wdat;

    always_comb begin
        fill_full = (fill == FW'(DELAY_SAMPLES));
        old_att   = old >>> ATTEN_SHIFT;
        wet_sum   = {din[15], din} + {old_att[15], old_att};
        if (wet_sum[16] != wet_sum[15])
            wet_sat = wet_sum[16] ? 16'sh8000 : 16'sh7fff;
        else
            wet_sat = wet_sum[15:0];
        mem_we   = (state == MIX) && !reset;
        mem_re   = (state == IDLE) && new_frame && !reset;
        mem_wdat = (FEEDBACK != 0) ? wet_sat : din;
    end

    // Single port: reads only happen in IDLE and writes only in MIX, so they never collide.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[ptr] <= mem_wdat;
        else if (mem_re)
            rd_dat <= mem[ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            fill       <= '0;
            din        <= '0;
            old        <= '0;
            sample_out <= 16'h0000;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_frame) begin
                        din   <= sample_in;
                        state <= READ;
                    end
                end
                READ: begin
                    // Memory is never cleared; until the line has been filled once its contents are stale.
                    old   <= fill_full ? rd_dat : 16'sd0;
                    state <= MIX;
                end
                MIX: begin
                    sample_out <= enable ? wet_sat : din;
                    out_valid  <= 1'b1;
                    ptr        <= ptr + 1'b1;
                    if (!fill_full)
                        fill <= fill + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_echo_effect.sv
// Scoreboard bench for echo_effect: three parameterisations share stimulus, one is selected per test.
module tb_echo_effect;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        new_frame = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic [15:0] so_a, so_s, so_f;
    logic        ov_a, ov_s, ov_f;

    int   sel = 0;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    logic rst_q;
    logic [15:0] prev_so = 16'h0000;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;
    exp_t sb[$];

    echo_effect #(.DELAY_SAMPLES(4), .ATTEN_SHIFT(1), .FEEDBACK(0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .new_frame(new_frame),
        .sample_in(sample_in), .sample_out(so_a), .out_valid(ov_a));
    echo_effect #(.DELAY_SAMPLES(4), .ATTEN_SHIFT(0), .FEEDBACK(0)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .new_frame(new_frame),
        .sample_in(sample_in), .sample_out(so_s), .out_valid(ov_s));
    echo_effect #(.DELAY_SAMPLES(2), .ATTEN_SHIFT(1), .FEEDBACK(1)) dut_f (
        .clk(clk), .reset(reset), .enable(enable), .new_frame(new_frame),
        .sample_in(sample_in), .sample_out(so_f), .out_valid(ov_f));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    function automatic logic [15:0] cur_so();
        case (sel)
            0:       return so_a;
            1:       return so_s;
            default: return so_f;
        endcase
    endfunction

    function automatic logic cur_ov();
        case (sel)
            0:       return ov_a;
            1:       return ov_s;
            default: return ov_f;
        endcase
    endfunction

    // Monitor: every out_valid pops one expectation; between pulses the output must hold.
    always @(negedge clk) begin
        exp_t e;
        if (cur_ov() === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: sel=%0d cyc=%0d sample_out=%0d, required no pulse",
                         sel, cyc, $signed(cur_so()));
            end else begin
                e = sb.pop_front();
                if (cur_so() !== e.val || cyc != e.due) begin
                    errors++;
                    $display("FAIL frame_out: sel=%0d got %0d at cyc %0d, required %0d at cyc %0d",
                             sel, $signed(cur_so()), cyc, $signed(e.val), e.due);
                end
            end
        end else if (rst_q === 1'b0) begin
            vectors++;
            if (cur_so() !== prev_so) begin
                errors++;
                $display("FAIL hold: sel=%0d cyc=%0d sample_out=%0d, required %0d",
                         sel, cyc, $signed(cur_so()), $signed(prev_so));
            end
        end
        prev_so = cur_so();
    end

    task automatic check_reset_outputs();
        vectors++;
        if (cur_so() !== 16'h0000 || cur_ov() !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%0d sample_out=%h out_valid=%b, required 0000/0",
                     sel, cur_so(), cur_ov());
        end
    endtask

    // Reset held for several edges while new_frame keeps pulsing.
    task automatic do_reset(input int s);
        @(negedge clk); reset = 1'b1; new_frame = 1'b1;
        @(negedge clk); sel = s; new_frame = 1'b0; check_reset_outputs();
        @(negedge clk); new_frame = 1'b1; check_reset_outputs();
        @(negedge clk); reset = 1'b0; new_frame = 1'b0;
    endtask

    task automatic frame(input int x, input int e);
        @(negedge clk);
        sample_in = 16'(x);
        new_frame = 1'b1;
        sb.push_back('{16'(e), cyc + 3});
        @(negedge clk); new_frame = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Strobe held for two consecutive cycles: must still be a single frame.
    task automatic frame_double(input int x, input int e);
        @(negedge clk);
        sample_in = 16'(x);
        new_frame = 1'b1;
        sb.push_back('{16'(e), cyc + 3});
        @(negedge clk);
        @(negedge clk); new_frame = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL timeout_%s: %0d outputs missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        // Fill masking with the default-style instance.
        do_reset(0);
        enable = 1'b1;
        repeat (4) frame(1000, 1000);
        frame(1000, 1500);
        drain("fill");

        // Abort a frame by resetting while it is in MIX: no pulse, no write, ptr back to 0.
        @(negedge clk); sample_in = 16'd5555; new_frame = 1'b1;
        @(negedge clk); new_frame = 1'b0;
        do_reset(0);
        frame(100, 100);
        frame(200, 200);
        frame(300, 300);
        frame(400, 400);
        frame(0, 50);
        frame(0, 100);
        drain("abort");

        // Saturation, both rails.
        do_reset(1);
        repeat (4) frame(30000, 30000);
        frame(30000, 32767);
        drain("sat_pos");
        do_reset(1);
        repeat (4) frame(-30000, -30000);
        frame(-30000, -32768);
        drain("sat_neg");

        // Bypass then echo enabled mid-stream.
        do_reset(0);
        enable = 1'b0;
        frame(10, 10);
        frame(20, 20);
        frame(30, 30);
        frame(40, 40);
        frame(50, 50);
        enable = 1'b1;
        frame(60, 70);
        drain("bypass");

        // Feedback with a two-entry line wrapping repeatedly.
        do_reset(2);
        frame(8192, 8192);
        frame(0, 0);
        frame(0, 4096);
        frame(0, 0);
        frame(0, 2048);
        frame(0, 0);
        frame(0, 1024);
        drain("feedback");

        // Back-to-back strobes.
        do_reset(0);
        frame_double(7, 7);
        frame(8, 8);
        frame(9, 9);
        frame(10, 10);
        frame(0, 3);
        drain("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
